// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the received-byte and status outputs.
// The receiver takes the slave side and whoever feeds the line takes the master side.
interface uart_rx_if;
    logic       serialRX;
    logic [7:0] dataRX;
    logic       dataRXValid;
    logic       activeRX;
    logic       frameErr;

    modport master (
        output serialRX,
        input  dataRX,
        input  dataRXValid,
        input  activeRX,
        input  frameErr
    );

    modport slave (
        input  serialRX,
        output dataRX,
        output dataRXValid,
        output activeRX,
        output frameErr
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling,
// one-cycle dataRXValid / frameErr pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    logic       rxMeta;
    logic       rxSync;
    logic       rxPrev;
    logic [1:0] syncFill;
    logic       lineArmed;
    logic       startEdge;

    logic [7:0] dataReg;
    logic       validReg;
    logic       activeReg;
    logic       errReg;

    // The synchronizer comes out of reset holding 1s, not line samples. lineArmed waits for a
    // genuine high from the line so a frame cut by reset cannot fake a start edge on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            rxPrev    <= 1'b1;
            syncFill  <= 2'd0;
            lineArmed <= 1'b0;
        end else begin
            rxMeta <= bus.serialRX;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
            if (!syncFill[1]) begin
                syncFill <= syncFill + 2'd1;
            end
            if (syncFill[1] && rxSync) begin
                lineArmed <= 1'b1;
            end
        end
    end

    assign startEdge = lineArmed & rxPrev & ~rxSync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitIdx    <= 3'd0;
            shiftReg  <= 8'h00;
            dataReg   <= 8'h00;
            validReg  <= 1'b0;
            activeReg <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            validReg <= 1'b0;
            errReg   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    bitIdx <= 3'd0;
                    if (startEdge) begin
                        state     <= START_BIT;
                        activeReg <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rxSync) begin
                            state <= DATA;
                        end else begin
                            state     <= IDLE;
                            activeReg <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt              <= '0;
                        shiftReg[bitIdx] <= rxSync;
                        if (bitIdx == 3'd7) begin
                            bitIdx <= 3'd0;
                            state  <= STOP_BIT;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP_BIT: begin
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        activeReg <= 1'b0;
                        if (rxSync) begin
                            dataReg  <= shiftReg;
                            validReg <= 1'b1;
                        end else begin
                            errReg <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bitIdx    <= 3'd0;
                    activeReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dataRX      = dataReg;
    assign bus.dataRXValid = validReg;
    assign bus.activeRX    = activeReg;
    assign bus.frameErr    = errReg;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (8 and 87 clocks per bit) fed directed 8N1 frames;
// expected bytes / frame errors are queued at send time and popped by a pulse monitor.
module tb_uart_rx;
    localparam int CPB  = 8;
    localparam int HALF = (CPB - 1) / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if bus8 ();
    uart_rx_if bus87 ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    uart_rx #(.CLKS_PER_BIT(87)) dut87 (
        .clk (clk),
        .rst (rst),
        .bus (bus87.slave)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t q8[$];
    exp_t q87[$];

    int         nChecks = 0;
    int         nFail   = 0;
    int         activeCnt = 0;
    logic [7:0] lastGood8  = 8'h00;
    logic [7:0] lastGood87 = 8'h00;
    logic [7:0] prev8  = 8'h00;
    logic [7:0] prev87 = 8'h00;
    logic       rstPrev = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        nChecks++;
        if (act < lo || act > hi) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic hold8(input logic v, input int n);
        bus8.serialRX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold87(input logic v, input int n);
        bus87.serialRX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame8(input logic [7:0] d, input logic stopV);
        exp_t e;
        e.err  = ~stopV;
        e.data = stopV ? d : lastGood8;
        q8.push_back(e);
        if (stopV) lastGood8 = d;
        hold8(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold8(d[i], CPB);
        hold8(stopV, CPB);
    endtask

    task automatic sendFrame87(input logic [7:0] d, input int period);
        exp_t e;
        e.err  = 1'b0;
        e.data = d;
        q87.push_back(e);
        lastGood87 = d;
        hold87(1'b0, period);
        for (int i = 0; i < 8; i++) hold87(d[i], period);
        hold87(1'b1, period);
    endtask

    // Pulse monitor: pops the scoreboard on every valid/error pulse and checks dataRX holds otherwise
    always @(negedge clk) begin
        exp_t e;
        if (bus8.activeRX) activeCnt++;
        if (bus8.dataRXValid || bus8.frameErr) begin
            check("excl8", {31'd0, bus8.dataRXValid & bus8.frameErr}, 32'd0);
            if (q8.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected8: got valid=%0b err=%0b data=0x%0h, expected no pulse (t=%0t)",
                         bus8.dataRXValid, bus8.frameErr, bus8.dataRX, $time);
            end else begin
                e = q8.pop_front();
                check("kind8", {31'd0, bus8.frameErr}, {31'd0, e.err});
                check("data8", {24'd0, bus8.dataRX}, {24'd0, e.data});
            end
        end else if (!rst && !rstPrev) begin
            check("hold8", {24'd0, bus8.dataRX}, {24'd0, prev8});
        end
        if (bus87.dataRXValid || bus87.frameErr) begin
            if (q87.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected87: got valid=%0b err=%0b data=0x%0h, expected no pulse (t=%0t)",
                         bus87.dataRXValid, bus87.frameErr, bus87.dataRX, $time);
            end else begin
                e = q87.pop_front();
                check("kind87", {31'd0, bus87.frameErr}, {31'd0, e.err});
                check("data87", {24'd0, bus87.dataRX}, {24'd0, e.data});
            end
        end else if (!rst && !rstPrev) begin
            check("hold87", {24'd0, bus87.dataRX}, {24'd0, prev87});
        end
        prev8   = bus8.dataRX;
        prev87  = bus87.dataRX;
        rstPrev = rst;
    end

    logic [7:0] b81;

    initial begin
        rst            = 1'b1;
        bus8.serialRX  = 1'b1;
        bus87.serialRX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstData8",   {24'd0, bus8.dataRX}, 32'h0);
        check("rstValid8",  {31'd0, bus8.dataRXValid}, 32'h0);
        check("rstActive8", {31'd0, bus8.activeRX}, 32'h0);
        check("rstErr8",    {31'd0, bus8.frameErr}, 32'h0);
        check("rstData87",  {24'd0, bus87.dataRX}, 32'h0);
        check("rstValid87", {31'd0, bus87.dataRXValid}, 32'h0);
        check("rstActive87", {31'd0, bus87.activeRX}, 32'h0);
        check("rstErr87",   {31'd0, bus87.frameErr}, 32'h0);
        rst = 1'b0;
        hold8(1'b1, 20);

        // Clean 0xA5 and the length of the activeRX window
        activeCnt = 0;
        sendFrame8(8'hA5, 1'b1);
        hold8(1'b1, 20);
        checkRange("activeLenA5", activeCnt, 75, 77);
        check("dataA5", {24'd0, bus8.dataRX}, 32'hA5);

        // Two-cycle low glitch is rejected at the half-bit point
        activeCnt = 0;
        hold8(1'b0, 2);
        hold8(1'b1, HALF + 3);
        check("glitchActiveLow", {31'd0, bus8.activeRX}, 32'h0);
        checkRange("glitchActiveSeen", activeCnt, 1, HALF + 3);
        hold8(1'b1, 20);

        // Framing error, break held low, then recovery with 0x01
        sendFrame8(8'h3C, 1'b0);
        hold8(1'b0, 50);
        check("breakIdle", {31'd0, bus8.activeRX}, 32'h0);
        hold8(1'b1, 20);
        sendFrame8(8'h01, 1'b1);
        hold8(1'b1, 20);
        check("data01", {24'd0, bus8.dataRX}, 32'h01);

        // Back-to-back frames with no idle gap
        sendFrame8(8'h00, 1'b1);
        sendFrame8(8'hFF, 1'b1);
        sendFrame8(8'h55, 1'b1);
        hold8(1'b1, 20);
        check("data55", {24'd0, bus8.dataRX}, 32'h55);

        // 0x81 interrupted by a one-cycle reset during data bit 4
        b81 = 8'h81;
        hold8(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold8(b81[i], CPB);
        hold8(b81[4], 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lastGood8 = 8'h00;
        hold8(b81[4], 3);
        for (int i = 5; i < 8; i++) hold8(b81[i], CPB);
        hold8(1'b1, CPB);
        hold8(1'b1, 20);
        check("abortActive", {31'd0, bus8.activeRX}, 32'h0);
        check("abortData", {24'd0, bus8.dataRX}, 32'h00);
        sendFrame8(8'h7E, 1'b1);
        hold8(1'b1, 20);
        check("data7E", {24'd0, bus8.dataRX}, 32'h7E);

        // Baud tolerance at 87 clocks per bit
        sendFrame87(8'hC3, 86);
        hold87(1'b1, 200);
        check("dataC3fast", {24'd0, bus87.dataRX}, 32'hC3);
        sendFrame87(8'hC3, 88);
        hold87(1'b1, 200);
        check("dataC3slow", {24'd0, bus87.dataRX}, 32'hC3);

        for (int i = 0; i < 2000 && (q8.size() != 0 || q87.size() != 0); i++) @(posedge clk);
        #1;
        check("pending8", q8.size(), 32'd0);
        check("pending87", q87.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
